// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, ALU op and
// ALU-B source encodings, control FSM state encoding and opcode class bundle.
package mips_ctrl_pkg;

    localparam logic [5:0] R_TYPE = 6'h00;
    localparam logic [5:0] ADDI   = 6'h08;
    localparam logic [5:0] LUI    = 6'h0F;
    localparam logic [5:0] ORI    = 6'h0D;
    localparam logic [5:0] ANDI   = 6'h0C;
    localparam logic [5:0] LW     = 6'h23;
    localparam logic [5:0] SW     = 6'h2B;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] BNE    = 6'h05;

    localparam logic [2:0] ALU_FUNCT = 3'b111;
    localparam logic [2:0] ALU_ADD   = 3'b100;
    localparam logic [2:0] ALU_LUI   = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_ADDR  = 3'b011;
    localparam logic [2:0] ALU_SUB   = 3'b101;

    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    typedef enum logic [3:0] {
        S_INIT     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_ALU   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_e;

    typedef struct packed {
        logic r_type;
        logic imm;
        logic ld;
        logic st;
        logic br;
        logic ill;
    } op_class_t;

endpackage

// File: rtl/multicycle_control_opcode_class_decoder.sv
// Maps the IR opcode to a one-hot instruction class and the ALU op used by
// the immediate-arithmetic group. Purely combinational.
module opcode_class_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    output op_class_t  cls_o,
    output logic [2:0] imm_alu_op_o
);

    always_comb begin
        cls_o        = '0;
        imm_alu_op_o = ALU_ADD;
        case (opcode_i)
            R_TYPE:  cls_o.r_type = 1'b1;
            ADDI:    begin cls_o.imm = 1'b1; imm_alu_op_o = ALU_ADD; end
            LUI:     begin cls_o.imm = 1'b1; imm_alu_op_o = ALU_LUI; end
            ORI:     begin cls_o.imm = 1'b1; imm_alu_op_o = ALU_OR;  end
            ANDI:    begin cls_o.imm = 1'b1; imm_alu_op_o = ALU_AND; end
            LW:      cls_o.ld = 1'b1;
            SW:      cls_o.st = 1'b1;
            BEQ,
            BNE:     cls_o.br = 1'b1;
            default: cls_o.ill = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath; only FETCH strobes and
// MEM_WR completion follow mem_ready_i combinationally.
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_src_o,
    output logic       branch_eq_o,
    output logic       branch_ne_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic       instr_done_o,
    output logic       illegal_o
);

    state_e     state_q, state_d;
    op_class_t  cls;
    logic [2:0] imm_alu_op;

    opcode_class_decoder u_dec (
        .opcode_i     (opcode_i),
        .cls_o        (cls),
        .imm_alu_op_o (imm_alu_op)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_INIT;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        pc_write_o   = 1'b0;
        pc_src_o     = 1'b0;
        branch_eq_o  = 1'b0;
        branch_ne_o  = 1'b0;
        iord_o       = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRC_B_REG;
        alu_op_o     = ALU_LUI;
        instr_done_o = 1'b0;
        illegal_o    = 1'b0;

        case (state_q)
            S_INIT: state_d = S_FETCH;

            // PC+4 is computed every FETCH cycle; it only lands when memory is ready.
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SRC_B_FOUR;
                alu_op_o    = ALU_ADD;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
                if (mem_ready_i) state_d = S_DECODE;
            end

            S_DECODE: begin
                alu_src_b_o = SRC_B_IMM_SH2;
                alu_op_o    = ALU_ADD;
                case (1'b1)
                    cls.r_type:     state_d = S_EXEC_R;
                    cls.imm:        state_d = S_EXEC_I;
                    cls.ld, cls.st: state_d = S_MEM_ADDR;
                    cls.br:         state_d = S_BRANCH;
                    cls.ill:        state_d = S_ILLEGAL;
                    default:        state_d = S_ILLEGAL;
                endcase
            end

            S_EXEC_R: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRC_B_REG;
                alu_op_o    = ALU_FUNCT;
                state_d     = S_WB_ALU;
            end

            S_EXEC_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRC_B_IMM;
                alu_op_o    = imm_alu_op;
                state_d     = S_WB_ALU;
            end

            S_WB_ALU: begin
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
                reg_dst_o    = cls.r_type;
                state_d      = S_FETCH;
            end

            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRC_B_IMM;
                alu_op_o    = ALU_ADDR;
                state_d     = cls.st ? S_MEM_WR : S_MEM_RD;
            end

            S_MEM_RD: begin
                iord_o     = 1'b1;
                mem_read_o = 1'b1;
                if (mem_ready_i) state_d = S_WB_MEM;
            end

            S_WB_MEM: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
            end

            S_MEM_WR: begin
                iord_o       = 1'b1;
                mem_write_o  = 1'b1;
                instr_done_o = mem_ready_i;
                if (mem_ready_i) state_d = S_FETCH;
            end

            S_BRANCH: begin
                alu_src_a_o  = 1'b1;
                alu_src_b_o  = SRC_B_REG;
                alu_op_o     = ALU_SUB;
                pc_src_o     = 1'b1;
                instr_done_o = 1'b1;
                branch_eq_o  = (opcode_i == BEQ);
                branch_ne_o  = (opcode_i == BNE);
                state_d      = S_FETCH;
            end

            S_ILLEGAL: begin
                illegal_o    = 1'b1;
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
            end

            default: state_d = S_INIT;
        endcase
    end

endmodule
